// File: rtl/router_reg.sv
// Router datapath register stage: header latch, FIFO write data, full-hold byte, parity check.
// Optional payload length check is built when ROUTER_REG_LEN_CHECK_EN is defined.
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_packet_valid,
    output logic                  err,
    output logic                  len_err
);

    localparam int DW = DATA_WIDTH;

    logic [DW-1:0] hdr_q, hdr_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          hold_pl_q, hold_pl_d;
    logic [DW-1:0] int_par_q, int_par_d;
    logic [DW-1:0] pkt_par_q, pkt_par_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          parity_done_q, parity_done_d;
    logic          lpv_q, lpv_d;
    logic          err_q, err_d;

    logic new_pkt;
    logic fold_ld;
    logic fold_laf;

    assign new_pkt  = detect_add & pkt_valid & (data_in[1:0] != 2'b11);
    assign fold_ld  = ld_state & pkt_valid & ~fifo_full;
    assign fold_laf = laf_state & hold_pl_q;

    always_comb begin
        hdr_d         = hdr_q;
        hold_d        = hold_q;
        hold_pl_d     = hold_pl_q;
        int_par_d     = int_par_q;
        pkt_par_d     = pkt_par_q;
        dout_d        = dout_q;
        parity_done_d = parity_done_q;
        lpv_d         = lpv_q;
        err_d         = err_q;

        if (new_pkt) begin
            hdr_d = data_in;
        end

        if (lfd_state) begin
            dout_d = hdr_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (laf_state) begin
            dout_d = hold_q;
        end

        if (ld_state && fifo_full) begin
            hold_d    = data_in;
            hold_pl_d = pkt_valid;
        end

        // full_state bytes are deliberately not folded; the held byte is counted once, in laf_state
        if (new_pkt) begin
            int_par_d = '0;
        end else if (lfd_state) begin
            int_par_d = hdr_q;
        end else if (fold_ld) begin
            int_par_d = int_par_q ^ data_in;
        end else if (fold_laf) begin
            int_par_d = int_par_q ^ hold_q;
        end

        if (new_pkt) begin
            parity_done_d = 1'b0;
        end else if (ld_state && !pkt_valid && !fifo_full) begin
            pkt_par_d     = data_in;
            parity_done_d = 1'b1;
        end else if (laf_state && !hold_pl_q) begin
            pkt_par_d     = hold_q;
            parity_done_d = 1'b1;
        end

        if (rst_int_reg || detect_add) begin
            lpv_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            lpv_d = 1'b1;
        end

        if (new_pkt) begin
            err_d = 1'b0;
        end else if (rst_int_reg) begin
            err_d = (int_par_q != pkt_par_q);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hdr_q         <= '0;
            hold_q        <= '0;
            hold_pl_q     <= 1'b0;
            int_par_q     <= '0;
            pkt_par_q     <= '0;
            dout_q        <= '0;
            parity_done_q <= 1'b0;
            lpv_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            hdr_q         <= hdr_d;
            hold_q        <= hold_d;
            hold_pl_q     <= hold_pl_d;
            int_par_q     <= int_par_d;
            pkt_par_q     <= pkt_par_d;
            dout_q        <= dout_d;
            parity_done_q <= parity_done_d;
            lpv_q         <= lpv_d;
            err_q         <= err_d;
        end
    end

`ifdef ROUTER_REG_LEN_CHECK_EN
    logic [DW-2:0] cnt_q, cnt_d;
    logic          len_err_q, len_err_d;

    always_comb begin
        cnt_d     = cnt_q;
        len_err_d = len_err_q;
        if (new_pkt) begin
            cnt_d     = '0;
            len_err_d = 1'b0;
        end else begin
            if ((fold_ld || fold_laf) && (cnt_q != {(DW-1){1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (rst_int_reg) begin
                len_err_d = (cnt_q != {1'b0, hdr_q[DW-1:2]});
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

    assign dout             = dout_q;
    assign parity_done      = parity_done_q;
    assign low_packet_valid = lpv_q;
    assign err              = err_q;

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: FSM strobes driven from tables, FIFO write data scoreboarded.
module tb_router_reg;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0] dout;
    logic       parity_done, low_packet_valid, err, len_err;

    always #5 clock = ~clock;

    router_reg #(.DATA_WIDTH(8)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (dout),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err),
        .len_err          (len_err)
    );

`ifdef ROUTER_REG_LEN_CHECK_EN
    localparam logic EXP_T6_LEN = 1'b1;
`else
    localparam logic EXP_T6_LEN = 1'b0;
`endif

    localparam logic [5:0] S_DA   = 6'b100000;
    localparam logic [5:0] S_LFD  = 6'b010000;
    localparam logic [5:0] S_LD   = 6'b001000;
    localparam logic [5:0] S_LAF  = 6'b000100;
    localparam logic [5:0] S_FULL = 6'b000010;
    localparam logic [5:0] S_RST  = 6'b000001;

    logic [7:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [5:0] st, input logic [7:0] d, input logic pv, input logic ff);
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
        data_in   = d;
        pkt_valid = pv;
        fifo_full = ff;
        @(posedge clock);
        #1;
        if (st == S_LFD || st == S_LAF || (st == S_LD && !ff)) begin
            if (exp_q.size() == 0) check("dout_unexpected_write", exp_q.size(), 1);
            else                   check("dout", dout, exp_q.pop_front());
        end
    endtask

    task automatic push5(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] e, input logic [7:0] f);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
        exp_q.push_back(e); exp_q.push_back(f);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_pdone"}, parity_done, 0);
        check({tag, "_lpv"}, low_packet_valid, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_len_err"}, len_err, 0);
    endtask

    initial begin
        resetn = 1'b0;
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = '0;
        data_in = 8'h00; pkt_valid = 1'b0; fifo_full = 1'b0;
        #12;
        check_all_zero("reset");
        resetn = 1'b1;
        @(posedge clock); #1;

        // T1: clean packet
        push5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
        step(S_DA,  8'h0D, 1, 0);
        step(S_LFD, 8'h11, 1, 0);
        step(S_LD,  8'h11, 1, 0);
        step(S_LD,  8'h22, 1, 0);
        step(S_LD,  8'h33, 1, 0);
        check("t1_lpv_before_par", low_packet_valid, 0);
        step(S_LD,  8'h0D, 0, 0);
        check("t1_pdone", parity_done, 1);
        check("t1_lpv", low_packet_valid, 1);
        step(S_RST, 8'h00, 0, 0);
        check("t1_err", err, 0);
        check("t1_len_err", len_err, 0);
        check("t1_lpv_cleared", low_packet_valid, 0);
        check("t1_queue", exp_q.size(), 0);

        // T2: bad parity, then addr 2'b11 ignored, then valid header clears
        push5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0E);
        step(S_DA,  8'h0D, 1, 0);
        step(S_LFD, 8'h11, 1, 0);
        step(S_LD,  8'h11, 1, 0);
        step(S_LD,  8'h22, 1, 0);
        step(S_LD,  8'h33, 1, 0);
        step(S_LD,  8'h0E, 0, 0);
        check("t2_err_before_chk", err, 0);
        step(S_RST, 8'h00, 0, 0);
        check("t2_err", err, 1);
        step(S_DA,  8'h0F, 1, 0);
        check("t2_err_addr3_ignored", err, 1);
        check("t2_pdone_addr3_ignored", parity_done, 1);
        step(S_DA,  8'h0D, 1, 0);
        check("t2_err_cleared", err, 0);
        check("t2_pdone_cleared", parity_done, 0);

        // T3: continue that packet with fifo_full on byte 22
        push5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
        step(S_LFD,  8'h11, 1, 0);
        step(S_LD,   8'h11, 1, 0);
        step(S_LD,   8'h22, 1, 1);
        check("t3_dout_frozen", dout, 8'h11);
        check("t3_lpv", low_packet_valid, 0);
        step(S_FULL, 8'h33, 1, 1);
        check("t3_dout_full_state", dout, 8'h11);
        step(S_LAF,  8'h33, 1, 0);
        check("t3_pdone_laf", parity_done, 0);
        step(S_LD,   8'h33, 1, 0);
        step(S_LD,   8'h0D, 0, 0);
        step(S_RST,  8'h00, 0, 0);
        check("t3_err", err, 0);
        check("t3_len_err", len_err, 0);
        check("t3_queue", exp_q.size(), 0);

        // T4: fifo_full on the parity byte
        push5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
        step(S_DA,   8'h0D, 1, 0);
        step(S_LFD,  8'h11, 1, 0);
        step(S_LD,   8'h11, 1, 0);
        step(S_LD,   8'h22, 1, 0);
        step(S_LD,   8'h33, 1, 0);
        step(S_LD,   8'h0D, 0, 1);
        check("t4_lpv", low_packet_valid, 1);
        check("t4_pdone_early", parity_done, 0);
        check("t4_dout_frozen", dout, 8'h33);
        step(S_FULL, 8'h0D, 0, 1);
        step(S_LAF,  8'h0D, 0, 0);
        check("t4_pdone", parity_done, 1);
        step(S_RST,  8'h00, 0, 0);
        check("t4_err", err, 0);
        check("t4_queue", exp_q.size(), 0);

        // T5: async reset mid-packet, then a fresh packet
        exp_q.push_back(8'h0D); exp_q.push_back(8'h11);
        step(S_DA,  8'h0D, 1, 0);
        step(S_LFD, 8'h11, 1, 0);
        step(S_LD,  8'h11, 1, 0);
        #2 resetn = 1'b0;
        #1 check_all_zero("t5_async");
        resetn = 1'b1;
        exp_q.push_back(8'h05); exp_q.push_back(8'h44); exp_q.push_back(8'h41);
        step(S_DA,  8'h05, 1, 0);
        step(S_LFD, 8'h44, 1, 0);
        step(S_LD,  8'h44, 1, 0);
        step(S_LD,  8'h41, 0, 0);
        step(S_RST, 8'h00, 0, 0);
        check("t5_err", err, 0);
        check("t5_len_err", len_err, 0);

        // T6: short payload with matching parity
        exp_q.push_back(8'h0D); exp_q.push_back(8'h11);
        exp_q.push_back(8'h22); exp_q.push_back(8'h3E);
        step(S_DA,  8'h0D, 1, 0);
        step(S_LFD, 8'h11, 1, 0);
        step(S_LD,  8'h11, 1, 0);
        step(S_LD,  8'h22, 1, 0);
        step(S_LD,  8'h3E, 0, 0);
        step(S_RST, 8'h00, 0, 0);
        check("t6_err", err, 0);
        check("t6_len_err", len_err, EXP_T6_LEN);
        check("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
